// File: rtl/vote_key_collect.sv
// rtl/vote_key_collect.sv - three-voter key collector with debounced keys and optional voting window
//
// Purpose:
//   Four raw keys (three voters plus a close/clear key) are each synchronized
//   and debounced. A debounced press of any voter opens a session. Further
//   voter presses are latched during the session. The session closes when all
//   three voters have pressed, when KEY_CLR is pressed, or when the optional
//   voting window expires. The result is then published. A KEY_CLR press in
//   RESULT returns the block to IDLE.
//
// Configuration macro:
//   VOTE_TIMEOUT_EN - when defined, a window counter closes COLLECT on its
//                     WINDOW_CYCLES-th cycle; when undefined there is no counter.
//
// Ports:
//   CLK_50M    in   single clock, all flops on posedge
//   RST_N      in   asynchronous active-low reset
//   KEY1..3    in   raw voter keys, 1 = pressed
//   KEY_CLR    in   raw close/clear key, 1 = pressed
//   VOTER      out  [2:0] latched voters {KEY3,KEY2,KEY1}
//   VOTE_CNT   out  [1:0] number of latched voters at close
//   VOTE_PASS  out  VOTE_CNT >= 2
//   VOTE_VALID out  one-cycle pulse in the first RESULT cycle
//   BUSY       out  1 while collecting
module vote_key_collect #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int WINDOW_CYCLES   = 250000000
) (
    input  logic       CLK_50M,
    input  logic       RST_N,
    input  logic       KEY1,
    input  logic       KEY2,
    input  logic       KEY3,
    input  logic       KEY_CLR,
    output logic [2:0] VOTER,
    output logic [1:0] VOTE_CNT,
    output logic       VOTE_PASS,
    output logic       VOTE_VALID,
    output logic       BUSY
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_RESULT
    } state_t;

    localparam logic [23:0] DB_LAST = 24'(DEBOUNCE_CYCLES - 1);

    state_t      state;
    logic [3:0]  key_raw;
    logic [3:0]  sync1;
    logic [3:0]  sync2;
    logic [3:0]  level;
    logic [3:0]  press;
    logic [23:0] db_cnt [4];

    logic [2:0]  voter_press;
    logic        clr_press;
    logic [2:0]  next_voter;
    logic [1:0]  vote_sum;
    logic        expire;
    logic        close_now;

    // Bit 3 is the clear key, bits 2..0 are the voters in VOTER order.
    assign key_raw = {KEY_CLR, KEY3, KEY2, KEY1};

    // Two-flop synchronizer followed by a per-key stability counter. The
    // counter only runs while the synchronized level differs from the
    // accepted level; any return to the accepted level restarts it. The
    // press pulse is registered together with the level change so it is
    // high exactly in the first cycle the new level 1 is visible.
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            sync1 <= '0;
            sync2 <= '0;
            level <= '0;
            press <= '0;
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
            for (int i = 0; i < 4; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] != level[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        level[i]  <= sync2[i];
                        db_cnt[i] <= '0;
                        press[i]  <= sync2[i];
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 24'd1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign voter_press = press[2:0];
    assign clr_press   = press[3];

    // Presses arriving in the closing cycle are folded into the result.
    assign next_voter = VOTER | voter_press;
    assign vote_sum   = {1'b0, next_voter[0]} + {1'b0, next_voter[1]}
                      + {1'b0, next_voter[2]};
    assign close_now  = (&next_voter) | clr_press | expire;

`ifdef VOTE_TIMEOUT_EN
    localparam logic [27:0] WIN_LAST = 28'(WINDOW_CYCLES - 1);

    logic [27:0] win_cnt;

    // Loaded on session open so the first COLLECT cycle sees WINDOW_CYCLES-1;
    // reaching zero marks the WINDOW_CYCLES-th COLLECT cycle.
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            win_cnt <= '0;
        end else if (state == S_IDLE && (|voter_press)) begin
            win_cnt <= WIN_LAST;
        end else if (state == S_COLLECT && win_cnt != '0) begin
            win_cnt <= win_cnt - 28'd1;
        end
    end

    assign expire = (state == S_COLLECT) && (win_cnt == '0);
`else
    // Constant 0 for every legal WINDOW_CYCLES; the window never closes.
    assign expire = (WINDOW_CYCLES < 1);
`endif

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            state      <= S_IDLE;
            VOTER      <= '0;
            VOTE_CNT   <= '0;
            VOTE_PASS  <= 1'b0;
            VOTE_VALID <= 1'b0;
            BUSY       <= 1'b0;
        end else begin
            VOTE_VALID <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (|voter_press) begin
                        state <= S_COLLECT;
                        VOTER <= voter_press;
                        BUSY  <= 1'b1;
                    end
                end
                S_COLLECT: begin
                    VOTER <= next_voter;
                    if (close_now) begin
                        state      <= S_RESULT;
                        BUSY       <= 1'b0;
                        VOTE_VALID <= 1'b1;
                        VOTE_CNT   <= vote_sum;
                        VOTE_PASS  <= vote_sum[1];
                    end
                end
                S_RESULT: begin
                    if (clr_press) begin
                        state     <= S_IDLE;
                        VOTER     <= '0;
                        VOTE_CNT  <= '0;
                        VOTE_PASS <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule
